multi_output_preprocessor: RTL and testbench

MULTI_OUTPUT_PREPROCESSOR -- requirements
Module: multi_output_preprocessor

---
 rtl/multi_output_preprocessor.sv | 263 ++++++++++++++++++++++++++
 tb/tb_multi_output_preprocessor.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_output_preprocessor.sv
// -----------------------------------------------------------------------------
// multi_output_preprocessor
//
// Multi-channel lock-data preprocessor. One sequential datapath serves
// N_CHAN channels. Each accepted sample is scaled by the channel's
// multiplier and shift, added to the channel's previous output, clamped
// to [min, max] and emitted as one output strobe. Every channel keeps a
// shadow copy of its parameters. update_in commits all shadow copies to
// the active copies at once and reloads every prev from its shadow init.
//
// Ports
//   clk_in, reset_in      clock, asynchronous active-high reset
//   data_in, chan_in      signed sample and its channel number
//   data_valid_in         sample valid; taken only while ready_out=1
//   ready_out             high only while the FSM is idle
//   wr_en_in              shadow parameter write strobe
//   wr_chan_in            channel addressed by the write
//   wr_sel_in             field select: 0=max 1=min 2=init 3=mult 4=shift
//   wr_data_in            write data (mult uses low W_MULT bits, shift low W_SH)
//   update_in             commit shadow to active for all channels
//   lock_en_in            per-channel lock enable, sampled in SEND
//   data_out, chan_out    processed result and its channel; held between strobes
//   data_valid_out        one-cycle result strobe
//   err_out               one-cycle pulse when a sample with a bad channel is dropped
// -----------------------------------------------------------------------------
module multi_output_preprocessor #(
    parameter int N_CHAN = 8,
    parameter int W_CH   = 3,
    parameter int W_IN   = 18,
    parameter int W_OUT  = 16,
    parameter int W_MULT = 8,
    parameter int W_SH   = 4
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic [W_IN-1:0]   data_in,
    input  logic [W_CH-1:0]   chan_in,
    input  logic              data_valid_in,
    output logic              ready_out,
    input  logic              wr_en_in,
    input  logic [W_CH-1:0]   wr_chan_in,
    input  logic [2:0]        wr_sel_in,
    input  logic [W_OUT-1:0]  wr_data_in,
    input  logic              update_in,
    input  logic [N_CHAN-1:0] lock_en_in,
    output logic [W_OUT-1:0]  data_out,
    output logic [W_CH-1:0]   chan_out,
    output logic              data_valid_out,
    output logic              err_out
);

    localparam int W_PROD = W_IN + W_MULT;  // full-precision product
    localparam int W_SUM  = W_PROD + 1;     // product plus prev, no overflow
    localparam int N_IDX  = 1 << W_CH;      // every value a channel field can take

    // One bit per encodable channel number: set where the channel exists.
    // A table lookup keeps the channel check legal when N_CHAN is a power of two.
    function automatic logic [N_IDX-1:0] chan_mask();
        logic [N_IDX-1:0] m;
        for (int i = 0; i < N_IDX; i++) begin
            m[i] = (i < N_CHAN);
        end
        return m;
    endfunction

    localparam logic [N_IDX-1:0] CHAN_OK = chan_mask();

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCALE,
        S_SUM,
        S_CLAMP,
        S_SEND
    } state_t;

    // Per-channel parameter set. The fields are stored as raw bits; the
    // datapath applies the signed interpretation where it reads them.
    typedef struct packed {
        logic [W_OUT-1:0]  max;
        logic [W_OUT-1:0]  min;
        logic [W_OUT-1:0]  init;
        logic [W_MULT-1:0] mult;
        logic [W_SH-1:0]   shift;
    } par_t;

    state_t state_q, state_d;

    par_t                    sh_q   [N_CHAN];
    par_t                    sh_d   [N_CHAN];
    par_t                    act_q  [N_CHAN];
    par_t                    act_d  [N_CHAN];
    logic signed [W_OUT-1:0] prev_q [N_CHAN];
    logic signed [W_OUT-1:0] prev_d [N_CHAN];

    logic signed [W_IN-1:0]   data_q, data_d;
    logic [W_CH-1:0]          chan_q, chan_d;
    logic signed [W_PROD-1:0] scaled_q, scaled_d;
    logic signed [W_SUM-1:0]  sum_q, sum_d;
    logic signed [W_OUT-1:0]  clamp_q, clamp_d;
    logic [W_OUT-1:0]         data_out_q, data_out_d;
    logic [W_CH-1:0]          chan_out_q, chan_out_d;
    logic                     data_valid_out_q, data_valid_out_d;
    logic                     err_out_q, err_out_d;

    logic ready, accept, reject;
    logic do_scale, do_sum, do_clamp, do_send;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: each combinational output gets a default first, so no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (data_valid_in && CHAN_OK[chan_in]) state_d = S_SCALE;
            S_SCALE: state_d = S_SUM;
            S_SUM:   state_d = S_CLAMP;
            S_CLAMP: state_d = S_SEND;
            S_SEND:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready    = (state_q == S_IDLE);
        accept   = ready && data_valid_in && CHAN_OK[chan_in];
        reject   = ready && data_valid_in && !CHAN_OK[chan_in];
        do_scale = (state_q == S_SCALE);
        do_sum   = (state_q == S_SUM);
        do_clamp = (state_q == S_CLAMP);
        do_send  = (state_q == S_SEND);
    end

    // ------------------------------------------------------------ datapath
    // Active parameters are read in the state that uses them. An update
    // that lands mid-transaction therefore affects only the later stages.
    par_t                     cur;
    logic [W_PROD-1:0]        prod_raw;
    logic signed [W_PROD-1:0] scale_val;
    logic signed [W_SUM-1:0]  sum_val, max_ext, min_ext, upper_val, clamp_ext;
    logic signed [W_OUT-1:0]  clamp_val, send_val;

    always_comb begin
        cur = act_q[chan_q];
        // Both operands are sign-extended to the product width, so the low
        // W_PROD bits of the product are the exact signed result.
        prod_raw  = {{W_MULT{data_q[W_IN-1]}}, data_q} *
                    {{W_IN{cur.mult[W_MULT-1]}}, cur.mult};
        scale_val = $signed(prod_raw) >>> cur.shift;

        sum_val = $signed({scaled_q[W_PROD-1], scaled_q}) +
                  $signed({{(W_SUM-W_OUT){prev_q[chan_q][W_OUT-1]}}, prev_q[chan_q]});

        // Upper bound first, then lower bound. If min > max the result is min.
        max_ext   = $signed({{(W_SUM-W_OUT){cur.max[W_OUT-1]}}, cur.max});
        min_ext   = $signed({{(W_SUM-W_OUT){cur.min[W_OUT-1]}}, cur.min});
        upper_val = (sum_q > max_ext) ? max_ext : sum_q;
        clamp_ext = (upper_val < min_ext) ? min_ext : upper_val;
        // The clamped value lies between max and min, so it always fits W_OUT.
        clamp_val = clamp_ext[W_OUT-1:0];

        send_val = lock_en_in[chan_q] ? clamp_q : $signed(cur.init);
    end

    always_comb begin
        data_d           = data_q;
        chan_d           = chan_q;
        scaled_d         = scaled_q;
        sum_d            = sum_q;
        clamp_d          = clamp_q;
        data_out_d       = data_out_q;
        chan_out_d       = chan_out_q;
        data_valid_out_d = do_send;
        err_out_d        = reject;

        if (accept) begin
            data_d = data_in;
            chan_d = chan_in;
        end
        if (do_scale) scaled_d = scale_val;
        if (do_sum)   sum_d    = sum_val;
        if (do_clamp) clamp_d  = clamp_val;
        if (do_send) begin
            data_out_d = send_val;
            chan_out_d = chan_q;
        end
    end

    // ------------------------------------------------------ parameter file
    always_comb begin
        sh_d   = sh_q;
        act_d  = act_q;
        prev_d = prev_q;

        if (wr_en_in && CHAN_OK[wr_chan_in]) begin
            case (wr_sel_in)
                3'd0:    sh_d[wr_chan_in].max   = wr_data_in;
                3'd1:    sh_d[wr_chan_in].min   = wr_data_in;
                3'd2:    sh_d[wr_chan_in].init  = wr_data_in;
                3'd3:    sh_d[wr_chan_in].mult  = wr_data_in[W_MULT-1:0];
                3'd4:    sh_d[wr_chan_in].shift = wr_data_in[W_SH-1:0];
                default: ;
            endcase
        end

        if (do_send) prev_d[chan_q] = send_val;

        // Applied last so a coincident update overrides the SEND prev write.
        if (update_in) begin
            act_d = sh_q;
            for (int i = 0; i < N_CHAN; i++) begin
                prev_d[i] = $signed(sh_q[i].init);
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            // NOTE: the parameter/prev file is flops rather than RAM and must read 0 after reset, so it is cleared here.
            for (int i = 0; i < N_CHAN; i++) begin
                sh_q[i]   <= '0;
                act_q[i]  <= '0;
                prev_q[i] <= '0;
            end
            data_q           <= '0;
            chan_q           <= '0;
            scaled_q         <= '0;
            sum_q            <= '0;
            clamp_q          <= '0;
            data_out_q       <= '0;
            chan_out_q       <= '0;
            data_valid_out_q <= 1'b0;
            err_out_q        <= 1'b0;
        end else begin
            sh_q             <= sh_d;
            act_q            <= act_d;
            prev_q           <= prev_d;
            data_q           <= data_d;
            chan_q           <= chan_d;
            scaled_q         <= scaled_d;
            sum_q            <= sum_d;
            clamp_q          <= clamp_d;
            data_out_q       <= data_out_d;
            chan_out_q       <= chan_out_d;
            data_valid_out_q <= data_valid_out_d;
            err_out_q        <= err_out_d;
        end
    end

    assign ready_out      = ready;
    assign data_out       = data_out_q;
    assign chan_out       = chan_out_q;
    assign data_valid_out = data_valid_out_q;
    assign err_out        = err_out_q;

endmodule

// File: tb/tb_multi_output_preprocessor.sv
// -----------------------------------------------------------------------------
// tb_multi_output_preprocessor
//
// Self-checking bench for multi_output_preprocessor. It runs the DUT with
// six channels, so chan_in = 6 and 7 are out-of-range values. The reference
// model keeps the shadow/active parameters and prev values as plain
// integers. It computes every expected output with ordinary arithmetic:
// scale, add prev, clamp, then apply the lock rule.
// -----------------------------------------------------------------------------
module tb_multi_output_preprocessor;

    localparam int N_CHAN = 6;
    localparam int W_CH   = 3;
    localparam int W_IN   = 18;
    localparam int W_OUT  = 16;
    localparam int W_MULT = 8;
    localparam int W_SH   = 4;

    localparam int F_MAX   = 0;
    localparam int F_MIN   = 1;
    localparam int F_INIT  = 2;
    localparam int F_MULT  = 3;
    localparam int F_SHIFT = 4;

    logic              clk_in = 1'b0;
    logic              reset_in;
    logic [W_IN-1:0]   data_in;
    logic [W_CH-1:0]   chan_in;
    logic              data_valid_in;
    logic              ready_out;
    logic              wr_en_in;
    logic [W_CH-1:0]   wr_chan_in;
    logic [2:0]        wr_sel_in;
    logic [W_OUT-1:0]  wr_data_in;
    logic              update_in;
    logic [N_CHAN-1:0] lock_en_in;
    logic [W_OUT-1:0]  data_out;
    logic [W_CH-1:0]   chan_out;
    logic              data_valid_out;
    logic              err_out;

    always #5 clk_in = ~clk_in;

    multi_output_preprocessor #(
        .N_CHAN(N_CHAN), .W_CH(W_CH), .W_IN(W_IN),
        .W_OUT(W_OUT), .W_MULT(W_MULT), .W_SH(W_SH)
    ) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .data_in       (data_in),
        .chan_in       (chan_in),
        .data_valid_in (data_valid_in),
        .ready_out     (ready_out),
        .wr_en_in      (wr_en_in),
        .wr_chan_in    (wr_chan_in),
        .wr_sel_in     (wr_sel_in),
        .wr_data_in    (wr_data_in),
        .update_in     (update_in),
        .lock_en_in    (lock_en_in),
        .data_out      (data_out),
        .chan_out      (chan_out),
        .data_valid_out(data_valid_out),
        .err_out       (err_out)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state
    int sh   [N_CHAN][5];
    int act  [N_CHAN][5];
    int prev [N_CHAN];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    function automatic int sx(input int v, input int w);
        int m;
        m = v & ((1 << w) - 1);
        if (m >= (1 << (w - 1))) m -= (1 << w);
        return m;
    endfunction

    // Advance one clock and sample 1 time unit after the active edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CHAN; c++) begin
            for (int f = 0; f < 5; f++) begin
                sh[c][f]  = 0;
                act[c][f] = 0;
            end
            prev[c] = 0;
        end
    endtask

    task automatic model_update();
        for (int c = 0; c < N_CHAN; c++) begin
            for (int f = 0; f < 5; f++) act[c][f] = sh[c][f];
            prev[c] = sh[c][F_INIT];
        end
    endtask

    task automatic wr(input int ch, input int sel, input int val);
        wr_en_in   = 1'b1;
        wr_chan_in = ch[W_CH-1:0];
        wr_sel_in  = sel[2:0];
        wr_data_in = val[W_OUT-1:0];
        step();
        wr_en_in = 1'b0;
        if (ch < N_CHAN && sel <= 4) begin
            if (sel == F_MULT)       sh[ch][sel] = sx(val, W_MULT);
            else if (sel == F_SHIFT) sh[ch][sel] = val & ((1 << W_SH) - 1);
            else                     sh[ch][sel] = sx(val, W_OUT);
        end
    endtask

    task automatic set_chan(input int ch, input int mx, input int mn, input int ini,
                            input int mul, input int shf);
        wr(ch, F_MAX, mx);
        wr(ch, F_MIN, mn);
        wr(ch, F_INIT, ini);
        wr(ch, F_MULT, mul);
        wr(ch, F_SHIFT, shf);
    endtask

    task automatic upd();
        update_in = 1'b1;
        step();
        update_in = 1'b0;
        model_update();
    endtask

    // One transaction, starting in IDLE. Optionally raise update_in on the
    // SEND cycle, or present an out-of-range input while the FSM is in SUM.
    task automatic run_txn(input int data, input int ch, input bit upd_at_send,
                           input bit inj_sum, input string tag);
        int prod, scaled, sum, r, exp_out;
        prod    = data * act[ch][F_MULT];
        scaled  = prod >>> act[ch][F_SHIFT];
        sum     = scaled + prev[ch];
        r       = (sum > act[ch][F_MAX]) ? act[ch][F_MAX] : sum;
        if (r < act[ch][F_MIN]) r = act[ch][F_MIN];
        exp_out = lock_en_in[ch] ? r : act[ch][F_INIT];

        data_in       = data[W_IN-1:0];
        chan_in       = ch[W_CH-1:0];
        data_valid_in = 1'b1;
        step();                                  // accept edge -> SCALE
        data_valid_in = 1'b0;
        check({tag, "_busy"}, 32'(ready_out), 32'd0);
        check({tag, "_strobe_off"}, 32'(data_valid_out), 32'd0);
        step();                                  // SUM
        if (inj_sum) begin
            data_valid_in = 1'b1;
            chan_in       = 3'(N_CHAN);
        end
        step();                                  // CLAMP
        data_valid_in = 1'b0;
        if (inj_sum) check({tag, "_no_err_busy"}, 32'(err_out), 32'd0);
        step();                                  // SEND
        check({tag, "_early"}, 32'(data_valid_out), 32'd0);
        if (upd_at_send) update_in = 1'b1;
        step();                                  // strobe visible
        update_in = 1'b0;
        check({tag, "_valid"}, 32'(data_valid_out), 32'd1);
        check({tag, "_data"}, 32'($signed(data_out)), 32'(exp_out));
        check({tag, "_chan"}, 32'(chan_out), 32'(ch));

        prev[ch] = exp_out;
        if (upd_at_send) model_update();
    endtask

    task automatic bad_input(input int ch);
        data_in       = 18'h1_2345;
        chan_in       = ch[W_CH-1:0];
        data_valid_in = 1'b1;
        step();
        data_valid_in = 1'b0;
        check("bad_err", 32'(err_out), 32'd1);
        check("bad_ready", 32'(ready_out), 32'd1);
        check("bad_no_valid", 32'(data_valid_out), 32'd0);
        step();
        check("bad_err_pulse", 32'(err_out), 32'd0);
        check("bad_no_valid2", 32'(data_valid_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_in      = 1'b1;
        data_in       = '0;
        chan_in       = '0;
        data_valid_in = 1'b0;
        wr_en_in      = 1'b0;
        wr_chan_in    = '0;
        wr_sel_in     = '0;
        wr_data_in    = '0;
        update_in     = 1'b0;
        lock_en_in    = '0;
        model_reset();

        step();
        step();
        reset_in = 1'b0;
        step();
        check("rst_ready", 32'(ready_out), 32'd1);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_chan", 32'(chan_out), 32'd0);
        check("rst_valid", 32'(data_valid_out), 32'd0);
        check("rst_err", 32'(err_out), 32'd0);

        // Ch2 accumulation: 100 + 75 = 175, then 175 + 75 = 250.
        set_chan(2, 1000, -1000, 100, 3, 1);
        upd();
        lock_en_in[2] = 1'b1;
        run_txn(50, 2, 1'b0, 1'b0, "ch2_a");
        check("ch2_a_lit", 32'($signed(data_out)), 32'd175);
        run_txn(50, 2, 1'b0, 1'b0, "ch2_b");
        check("ch2_b_lit", 32'($signed(data_out)), 32'd250);

        // Ch0 clamps: 400 -> 200 (upper); 200-1200 -> -500 (lower); min>max -> min.
        set_chan(0, 200, -500, 0, 4, 0);
        upd();
        lock_en_in[0] = 1'b1;
        run_txn(100, 0, 1'b0, 1'b0, "ch0_hi");
        check("ch0_hi_lit", 32'($signed(data_out)), 32'd200);
        run_txn(-300, 0, 1'b0, 1'b0, "ch0_lo");
        check("ch0_lo_lit", 32'($signed(data_out)), -32'sd500);
        wr(0, F_MIN, 300);
        upd();
        run_txn(10, 0, 1'b0, 1'b0, "ch0_inv");
        check("ch0_inv_lit", 32'($signed(data_out)), 32'd300);

        // Ch5 lock off holds init; lock on restarts accumulation from init.
        set_chan(5, 1000, -1000, -7, 1, 0);
        upd();
        lock_en_in[5] = 1'b0;
        run_txn(40, 5, 1'b0, 1'b0, "ch5_off_a");
        check("ch5_off_a_lit", 32'($signed(data_out)), -32'sd7);
        run_txn(123, 5, 1'b0, 1'b0, "ch5_off_b");
        check("ch5_off_b_lit", 32'($signed(data_out)), -32'sd7);
        lock_en_in[5] = 1'b1;
        run_txn(10, 5, 1'b0, 1'b0, "ch5_on");
        check("ch5_on_lit", 32'($signed(data_out)), 32'd3);

        // Ch1: an update on the SEND cycle overrides the prev write, not data_out.
        set_chan(1, 1000, -1000, 20, 2, 0);
        upd();
        lock_en_in[1] = 1'b1;
        run_txn(5, 1, 1'b0, 1'b0, "ch1_a");
        check("ch1_a_lit", 32'($signed(data_out)), 32'd30);
        wr(1, F_INIT, 50);
        run_txn(7, 1, 1'b1, 1'b0, "ch1_upd");
        check("ch1_upd_lit", 32'($signed(data_out)), 32'd44);
        run_txn(1, 1, 1'b0, 1'b0, "ch1_after");
        check("ch1_after_lit", 32'($signed(data_out)), 32'd52);

        // Out-of-range channel in IDLE, then a bad input presented during SUM.
        bad_input(N_CHAN);
        bad_input(7);
        run_txn(20, 2, 1'b0, 1'b1, "sum_inj");

        // Reset while the FSM is in CLAMP aborts the transaction.
        data_in       = 18'd33;
        chan_in       = 3'd2;
        data_valid_in = 1'b1;
        step();
        data_valid_in = 1'b0;
        step();
        step();
        #1;
        reset_in = 1'b1;
        #2;
        check("rclamp_ready", 32'(ready_out), 32'd1);
        check("rclamp_data", 32'(data_out), 32'd0);
        check("rclamp_chan", 32'(chan_out), 32'd0);
        check("rclamp_valid", 32'(data_valid_out), 32'd0);
        check("rclamp_err", 32'(err_out), 32'd0);
        step();
        reset_in = 1'b0;
        model_reset();
        step();
        check("rclamp_ready_after", 32'(ready_out), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check("rclamp_no_strobe", 32'(data_valid_out), 32'd0);
            step();
        end

        // Randomized traffic against the model.
        for (int it = 0; it < 80; it++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op <= 3) begin
                wr(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 65535)));
            end else if (op == 4) begin
                upd();
            end else if (op <= 8) begin
                lock_en_in = N_CHAN'($urandom());
                run_txn(sx(int'($urandom_range(0, (1 << W_IN) - 1)), W_IN),
                        int'($urandom_range(0, N_CHAN - 1)),
                        ($urandom_range(0, 3) == 0), 1'b0, "rnd");
            end else begin
                bad_input(int'($urandom_range(N_CHAN, 7)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
